// File: rtl/gray_ctrl_pkg.sv
// Shared types, command encodings and the single-bit-change helper for the
// gray_count_ctrl sequencer/checker.
package gray_ctrl_pkg;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_ABORT = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  // Widest counter the helper function can compare.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    CMD_RUN   = OP_RUN,
    CMD_CLEAR = OP_CLEAR,
    CMD_ABORT = OP_ABORT,
    CMD_NOP   = OP_NOP
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_CLR_CHK,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // True when exactly one bit differs (x nonzero and a power of two).
  function automatic logic one_bit_diff(input logic [GRAY_MAX_W-1:0] a,
                                        input logic [GRAY_MAX_W-1:0] b);
    logic [GRAY_MAX_W-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - GRAY_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_count_ctrl_if.sv
// Command handshake bundle between the sequencing logic (master) and
// gray_count_ctrl (slave).
interface gray_cmd_if
  import gray_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/gray_step_checker.sv
// On-line Gray transition checker: one-bit steps while enabled, hold while
// idle, zero after a clear. Optional GRAY_CTRL_ERRCNT_EN adds a fail counter.
module gray_step_checker
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             zero_chk,
  input  logic             err_clr,
`ifdef GRAY_CTRL_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             fail
);

  logic [WIDTH-1:0] gray_prev_reg;
  logic             en_q_reg;
  logic             clr_q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray_prev_reg <= '0;
      en_q_reg      <= 1'b0;
      clr_q_reg     <= 1'b0;
    end else begin
      gray_prev_reg <= gray_in;
      en_q_reg      <= cnt_en;
      clr_q_reg     <= cnt_clr;
    end
  end

  // en_q/clr_q describe what the counter was told last cycle, which is what
  // explains the change visible on gray_in now.
  always_comb begin
    fail = 1'b0;
    if (en_q_reg) begin
      fail = !one_bit_diff(GRAY_MAX_W'(gray_in), GRAY_MAX_W'(gray_prev_reg));
    end else if (!clr_q_reg) begin
      fail = (gray_in != gray_prev_reg);
    end
    if (zero_chk && (gray_in != '0)) begin
      fail = 1'b1;
    end
  end

`ifdef GRAY_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (fail && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: rtl/gray_count_ctrl.sv
// Sequencer for the gray_counter datapath: takes RUN/CLEAR/ABORT/NOP commands,
// drives enable/clear and flags bad Gray steps. GRAY_CTRL_ERRCNT_EN adds err_cnt.
module gray_count_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  gray_cmd_if.slave        cmd,
  output logic             cnt_en,
  output logic             cnt_clr,
  input  logic [WIDTH-1:0] gray_in,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef GRAY_CTRL_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic [LEN_W-1:0] steps_done
);

  state_e           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] steps_reg, steps_next;
  logic             err_reg;
  logic             cnt_en_reg;
  logic             cnt_clr_reg;
  logic             err_clr;
  logic             fail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      steps_reg   <= '0;
      err_reg     <= 1'b0;
      cnt_en_reg  <= 1'b0;
      cnt_clr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      steps_reg   <= steps_next;
      // Enable/clear are registered from the next state so they line up
      // exactly with the RUN and CLR cycles.
      cnt_en_reg  <= (state_next == ST_RUN);
      cnt_clr_reg <= (state_next == ST_CLR);
      if (err_clr) begin
        err_reg <= 1'b0;
      end else if (fail) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    steps_next    = steps_reg;
    err_clr       = 1'b0;
    cmd.cmd_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            CMD_RUN: begin
              len_next   = cmd.cmd_len;
              steps_next = '0;
              state_next = (cmd.cmd_len == '0) ? ST_DRAIN : ST_RUN;
            end
            CMD_CLEAR: begin
              err_clr    = 1'b1;
              state_next = ST_CLR;
            end
            default: ;
          endcase
        end
      end
      ST_CLR:     state_next = ST_CLR_CHK;
      ST_CLR_CHK: state_next = ST_DONE;
      ST_RUN: begin
        cmd.cmd_ready = (cmd.cmd_op == CMD_ABORT);
        // The enable of this cycle is already issued, so it always counts.
        steps_next = steps_reg + LEN_W'(1);
        if ((steps_reg + LEN_W'(1) == len_reg) ||
            (cmd.cmd_valid && (cmd.cmd_op == CMD_ABORT))) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN:   state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  gray_step_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (cnt_en_reg),
    .cnt_clr  (cnt_clr_reg),
    .gray_in  (gray_in),
    .zero_chk (state_reg == ST_CLR_CHK),
    .err_clr  (err_clr),
`ifdef GRAY_CTRL_ERRCNT_EN
    .err_cnt  (err_cnt),
`endif
    .fail     (fail)
  );

  assign cnt_en     = cnt_en_reg;
  assign cnt_clr    = cnt_clr_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign err        = err_reg;
  assign steps_done = steps_reg;

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Directed bench for gray_count_ctrl with a behavioural gray counter and a
// done-pulse scoreboard.
module tb_gray_count_ctrl;
  import gray_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cnt_en, cnt_clr, busy, done, err;
  logic [WIDTH-1:0] gray_in;
  logic [LEN_W-1:0] steps_done;
`ifdef GRAY_CTRL_ERRCNT_EN
  logic [7:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  gray_cmd_if #(.LEN_W(LEN_W)) cmd_bus ();

  gray_count_ctrl #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_bus.slave),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .gray_in    (gray_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
`ifdef GRAY_CTRL_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .steps_done (steps_done)
  );

  // Behavioural gray_counter with one-shot fault (bin 2 -> 0) and idle drift.
  logic [WIDTH-1:0] bin;
  int en_cycles = 0, clr_cycles = 0;
  int fault_tok = 0, fault_seen = 0, drift_tok = 0, drift_seen = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin <= '0;
    end else begin
      if (cnt_en) en_cycles <= en_cycles + 1;
      if (cnt_clr) begin
        clr_cycles <= clr_cycles + 1;
        bin <= '0;
      end else if (cnt_en) begin
        if ((fault_tok != fault_seen) && (bin == WIDTH'(2))) begin
          bin <= '0;
          fault_seen <= fault_tok;
        end else begin
          bin <= bin + 1'b1;
        end
      end else if (drift_tok != drift_seen) begin
        bin <= bin + 1'b1;
        drift_seen <= drift_tok;
      end
    end
  end

  assign gray_in = bin ^ (bin >> 1);

  typedef struct {
    logic [LEN_W-1:0] steps;
    logic             err;
    logic [7:0]       ecnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0, n_done = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic expect_done(input int steps, input int e, input int ec);
    exp_t x;
    x.steps = LEN_W'(steps);
    x.err   = e[0];
    x.ecnt  = 8'(ec);
    exp_q.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        check("done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_steps", 32'(steps_done), 32'(e.steps));
          check("done_err", 32'(err), 32'(e.err));
`ifdef GRAY_CTRL_ERRCNT_EN
          check("done_err_cnt", 32'(err_cnt), 32'(e.ecnt));
`endif
        end
      end
    end
  endtask

  task automatic send(input op_e op, input int len, output int ok);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_len   = LEN_W'(len);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_bus.cmd_ready) begin
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
        ok = 1;
        return;
      end
      @(negedge clk);
    end
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) return;
    end
    edges = -1;
  endtask

  task automatic done_one_cycle();
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int ok, edges, base, nd0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = CMD_NOP;
    cmd_bus.cmd_len   = '0;
    #1;
    check("reset_cnt_en", 32'(cnt_en), 0);
    check("reset_cnt_clr", 32'(cnt_clr), 0);
    check("reset_busy_done_err", 32'({busy, done, err}), 0);
    check("reset_steps", 32'(steps_done), 0);
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset in the third enable cycle of RUN 10.
    send(CMD_RUN, 10, ok);
    check("accept_run10", ok, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrun_cnt_en", 32'(cnt_en), 1);
    check("midrun_steps", 32'(steps_done), 2);
    rst = 1'b0;
    #1;
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_busy_done_err", 32'({busy, done, err}), 0);
    check("rst_steps", 32'(steps_done), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_release_ready", 32'(cmd_bus.cmd_ready), 1);

    // CLEAR then RUN 5.
    expect_done(0, 0, 0);
    base = clr_cycles;
    send(CMD_CLEAR, 0, ok);
    wait_done(20, edges);
    check("clear_latency", edges, 2);
    check("clear_pulses", clr_cycles - base, 1);
    done_one_cycle();
    expect_done(5, 0, 0);
    base = en_cycles;
    send(CMD_RUN, 5, ok);
    wait_done(40, edges);
    check("run5_latency", edges, 6);
    check("run5_en_cycles", en_cycles - base, 5);
    check("run5_gray", 32'(gray_in), 32'h7);
    done_one_cycle();

    // RUN with zero length.
    expect_done(0, 0, 0);
    base = en_cycles;
    send(CMD_RUN, 0, ok);
    wait_done(20, edges);
    check("run0_latency", edges, 1);
    check("run0_en_cycles", en_cycles - base, 0);

    // ABORT after three enables; a CLEAR offered meanwhile must be held off.
    expect_done(3, 0, 0);
    base = en_cycles;
    send(CMD_RUN, 10, ok);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = CMD_CLEAR;
    #1;
    check("clear_held_c1", 32'(cmd_bus.cmd_ready), 0);
    @(negedge clk);
    #1;
    check("clear_held_c2", 32'(cmd_bus.cmd_ready), 0);
    @(negedge clk);
    cmd_bus.cmd_op = CMD_ABORT;
    #1;
    check("abort_ready", 32'(cmd_bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    check("abort_cnt_en_off", 32'(cnt_en), 0);
    check("abort_steps", 32'(steps_done), 3);
    wait_done(20, edges);
    check("abort_latency", edges, 1);
    check("abort_en_cycles", en_cycles - base, 3);
    done_one_cycle();

    // NOP and ABORT while idle are accepted and do nothing.
    nd0 = n_done;
    send(CMD_NOP, 0, ok);
    check("accept_nop", ok, 1);
    send(CMD_ABORT, 0, ok);
    check("accept_idle_abort", ok, 1);
    repeat (4) @(negedge clk);
    check("idle_cmds_busy", 32'(busy), 0);
    check("idle_cmds_no_done", n_done - nd0, 0);

    // Fault injection: gray 0011 -> 0000 during RUN 5.
    expect_done(3, 0, 0);
    send(CMD_CLEAR, 0, ok);
    wait_done(20, edges);
    fault_tok++;
    expect_done(5, 1, 1);
    send(CMD_RUN, 5, ok);
    wait_done(40, edges);
    check("fault_latency", edges, 6);
    @(posedge clk);
    #1;
    check("fault_err_sticky", 32'(err), 1);
    expect_done(5, 0, 0);
    send(CMD_CLEAR, 0, ok);
    wait_done(20, edges);
    check("fault_clear_latency", edges, 2);

    // RUN 16 wraps 1000 -> 0000; then drift while idle.
    expect_done(16, 0, 0);
    send(CMD_RUN, 16, ok);
    wait_done(60, edges);
    check("wrap_latency", edges, 17);
    check("wrap_gray", 32'(gray_in), 0);
    done_one_cycle();
    check("wrap_no_err", 32'(err), 0);
    drift_tok++;
    repeat (3) @(posedge clk);
    #1;
    check("drift_err", 32'(err), 1);
    check("drift_busy", 32'(busy), 0);
`ifdef GRAY_CTRL_ERRCNT_EN
    check("drift_err_cnt", 32'(err_cnt), 1);
`endif

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_pulse_total", n_done, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
